// File: rtl/rb_writeback_rf.sv
`default_nettype none
// ============================================================================
// Module   : rb_writeback_rf
// Purpose  : RB (writeback) stage of the pipeline. Selects the writeback
//            value, commits it to the 32x32 integer register file, serves
//            the two decode read ports and exports the RB write so the
//            hazard/forward unit can forward from it.
// Options  : `define RB_WRITE_BYPASS_EN enables write-through bypass, so a
//            decode read of the register being committed returns the new
//            value in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rb_writeback_rf #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PC_INC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               PMAItoReg_RB,
  input  logic                     rd_wen_RB,
  input  logic [$clog2(NREG)-1:0]  rd_waddr_RB,
  input  logic [XLEN-1:0]          imm_RB,
  input  logic [XLEN-1:0]          mem_rdata_RB,
  input  logic [XLEN-1:0]          alu_result_RB,
  input  logic [XLEN-1:0]          PC_RB,
  input  logic [$clog2(NREG)-1:0]  rs1_raddr_D,
  input  logic [$clog2(NREG)-1:0]  rs2_raddr_D,
  output logic [XLEN-1:0]          rs1_rdata_D,
  output logic [XLEN-1:0]          rs2_rdata_D,
  output logic [XLEN-1:0]          wb_data_RB,
  output logic                     wb_fwd_valid_RB,
  output logic [$clog2(NREG)-1:0]  wb_fwd_addr_RB
);

  localparam int AW = $clog2(NREG);

  // Writeback source encodings.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_IMM  = 2'b10;
  localparam logic [1:0] SEL_LINK = 2'b11;

  localparam logic [XLEN-1:0] PC_INC_V = XLEN'(PC_INC);

  // Architectural storage. Entry 0 exists only to keep indexing uniform; it
  // is forced to zero every cycle and never read.
  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0][XLEN-1:0] regs_d;

  logic            commit;
  logic [XLEN-1:0] link_addr;

  // Link address wraps naturally in XLEN bits (0xFFFFFFFC + 4 -> 0).
  assign link_addr = PC_RB + PC_INC_V;

  // Writeback source selection; always driven so forwarding can use it.
  always_comb begin
    wb_data_RB = alu_result_RB;
    case (PMAItoReg_RB)
      SEL_ALU:  wb_data_RB = alu_result_RB;
      SEL_MEM:  wb_data_RB = mem_rdata_RB;
      SEL_IMM:  wb_data_RB = imm_RB;
      SEL_LINK: wb_data_RB = link_addr;
      default:  wb_data_RB = alu_result_RB;
    endcase
  end

  // A write to x0 is architecturally a no-op, so it is neither committed nor
  // advertised for forwarding.
  assign commit          = rd_wen_RB && (rd_waddr_RB != '0);
  assign wb_fwd_valid_RB = commit;
  assign wb_fwd_addr_RB  = rd_waddr_RB;

  // Next storage contents: single committed write, x0 pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[rd_waddr_RB] = wb_data_RB;
    end
    regs_d[0] = '0;
  end

  // Storage register; reset clears the file and drops any in-flight write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read-port resolution, shared by both decode ports.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0] raddr
  );
    logic [XLEN-1:0] val;
    val = regs_q[raddr];
`ifdef RB_WRITE_BYPASS_EN
    if (commit && (raddr == rd_waddr_RB)) begin
      val = wb_data_RB;
    end
`endif
    if (raddr == '0) begin
      val = '0;
    end
    return val;
  endfunction

  // Decode read ports, each resolved independently.
  always_comb begin
    rs1_rdata_D = read_port(rs1_raddr_D);
    rs2_rdata_D = read_port(rs2_raddr_D);
  end

endmodule
`default_nettype wire

// File: tb/tb_rb_writeback_rf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rb_writeback_rf
// Purpose  : Scoreboard bench for rb_writeback_rf. The stimulus process
//            predicts every cycle's outputs from an array model of the
//            register file and queues them; a monitor compares on the
//            falling edge. Honours RB_WRITE_BYPASS_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rb_writeback_rf;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] imm, mem, alu, pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, wb;
  logic        fwd_v;
  logic [4:0]  fwd_a;

  rb_writeback_rf dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PMAItoReg_RB   (sel),
    .rd_wen_RB      (wen),
    .rd_waddr_RB    (waddr),
    .imm_RB         (imm),
    .mem_rdata_RB   (mem),
    .alu_result_RB  (alu),
    .PC_RB          (pc),
    .rs1_raddr_D    (ra1),
    .rs2_raddr_D    (ra2),
    .rs1_rdata_D    (rd1),
    .rs2_rdata_D    (rd2),
    .wb_data_RB     (wb),
    .wb_fwd_valid_RB(fwd_v),
    .wb_fwd_addr_RB (fwd_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] wbv;
    logic        v;
    logic [4:0]  a;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT's outputs against the oldest prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("rs1_rdata", rd1, e.r1);
      check("rs2_rdata", rd2, e.r2);
      check("wb_data", wb, e.wbv);
      check("fwd_valid", {31'd0, fwd_v}, {31'd0, e.v});
      check("fwd_addr", {27'd0, fwd_a}, {27'd0, e.a});
    end
  end

  function automatic logic [31:0] pick_wb(input logic [1:0] s, input logic [31:0] a,
                                          input logic [31:0] m, input logic [31:0] i,
                                          input logic [31:0] p);
    case (s)
      2'd0:    return a;
      2'd1:    return m;
      2'd2:    return i;
      default: return p + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] ra, input bit wr,
                                           input logic [4:0] wa, input logic [31:0] v);
    if (ra == 5'd0) return 32'd0;
`ifdef RB_WRITE_BYPASS_EN
    if (wr && ra == wa) return v;
`endif
    return model[ra];
  endfunction

  // Apply one cycle of stimulus, predict its outputs, then advance the model.
  task automatic drive(input bit r, input bit w, input logic [4:0] wa, input logic [1:0] s,
                       input logic [31:0] i, input logic [31:0] m, input logic [31:0] a,
                       input logic [31:0] p, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    bit   wr;
    @(posedge clk);
    #1;
    rst_n = r; wen = w; waddr = wa; sel = s;
    imm = i; mem = m; alu = a; pc = p; ra1 = a1; ra2 = a2;
    wr    = w && (wa != 5'd0);
    e.wbv = pick_wb(s, a, m, i, p);
    e.v   = wr;
    e.a   = wa;
    e.r1  = exp_read(a1, wr, wa, e.wbv);
    e.r2  = exp_read(a2, wr, wa, e.wbv);
    sb.push_back(e);
    if (!r) begin
      for (int k = 0; k < 32; k++) model[k] = 32'd0;
    end else if (wr) begin
      model[wa] = e.wbv;
    end
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; waddr = '0; sel = '0;
    imm = '0; mem = '0; alu = '0; pc = '0; ra1 = '0; ra2 = '0;
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    // Initial reset to bring storage to a known state.
    repeat (2) @(posedge clk);

    // Reset held two cycles with a pending write to x5.
    drive(0, 1, 5, 2'b00, 0, 0, 32'h1234, 0, 5, 0);
    drive(0, 1, 5, 2'b00, 0, 0, 32'h1234, 0, 5, 0);
    drive(1, 0, 5, 2'b00, 0, 0, 32'h1234, 0, 5, 5);

    // Each writeback source into x3, read back on the following cycle.
    drive(1, 1, 3, 2'b00, 32'hC000_0000, 32'hB, 32'hA, 32'h100, 3, 3);
    drive(1, 1, 3, 2'b01, 32'hC000_0000, 32'hB, 32'hA, 32'h100, 3, 0);
    drive(1, 1, 3, 2'b10, 32'hC000_0000, 32'hB, 32'hA, 32'h100, 3, 3);
    drive(1, 1, 3, 2'b11, 32'hC000_0000, 32'hB, 32'hA, 32'h100, 3, 3);
    drive(1, 0, 3, 2'b00, 0, 0, 0, 0, 3, 3);

    // x0 protection.
    drive(1, 1, 0, 2'b00, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Same-cycle read of the register being written, then next cycle.
    drive(1, 1, 7, 2'b00, 0, 0, 32'hDEAD_BEEF, 0, 7, 7);
    drive(1, 0, 7, 2'b00, 0, 0, 0, 0, 7, 7);

    // Link address wraps to zero.
    drive(1, 1, 31, 2'b11, 0, 0, 0, 32'hFFFF_FFFC, 31, 31);
    drive(1, 0, 31, 2'b00, 0, 0, 0, 0, 31, 3);

    // Reset mid-stream discards the in-flight write.
    drive(1, 1, 9, 2'b00, 0, 0, 32'h55, 0, 9, 9);
    drive(0, 1, 9, 2'b00, 0, 0, 32'h66, 0, 9, 9);
    drive(1, 0, 9, 2'b00, 0, 0, 0, 0, 9, 3);

    // Fill a few registers, then randomized traffic.
    for (int k = 1; k < 32; k += 3)
      drive(1, 1, 5'(k), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
            5'(k - 1), 5'(k));
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), wa,
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    // Let the monitor drain, bounded.
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
